// File: rtl/mesm6_alu_seq_pkg.sv
// Types shared by the ALU macro-op sequencer and its micro-op ROM.
`include "mesm6_defines.sv"

package mesm6_alu_seq_pkg;

    localparam int unsigned DATA_W = 48;
    localparam int unsigned OP_W   = `ALU_OP_WIDTH;

    typedef enum logic [2:0] {
        CMD_AAX = 3'd0,
        CMD_AOX = 3'd1,
        CMD_AEX = 3'd2,
        CMD_ARX = 3'd3,
        CMD_ASX = 3'd4,
        CMD_ASN = 3'd5,
        CMD_ACX = 3'd6
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ASEL_ACC     = 2'd0,
        ASEL_OPERAND = 2'd1,
        ASEL_TEMP    = 2'd2
    } asel_t;

    typedef enum logic [1:0] {
        BSEL_OPERAND   = 2'd0,
        BSEL_SHIFT_IMM = 2'd1,
        BSEL_ZERO      = 2'd2,
        BSEL_ACC       = 2'd3
    } bsel_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        asel_t           a_sel;
        bsel_t           b_sel;
        logic            last;
    } uop_t;

    // The ASN immediate sits in the top bits of a shift word, same layout as ASX.
    function automatic logic [DATA_W-1:0] shift_word(input logic [6:0] imm);
        return {imm, 41'd0};
    endfunction

endpackage

// File: rtl/mesm6_alu_uop_rom.sv
// Combinational expansion of a macro opcode and micro-op index into one ALU micro-op.
`include "mesm6_defines.sv"

module mesm6_alu_uop_rom
    import mesm6_alu_seq_pkg::*;
(
    input  logic [2:0] cmd,
    input  logic       idx,
    output uop_t       uop,
    output logic       illegal
);

    // Table lookup; unknown opcodes produce a harmless NOP and raise illegal.
    always_comb begin
        uop.op    = `ALU_NOP;
        uop.a_sel = ASEL_ACC;
        uop.b_sel = BSEL_OPERAND;
        uop.last  = 1'b1;
        illegal   = 1'b0;
        case (cmd)
            CMD_AAX: uop.op = `ALU_AND;
            CMD_AOX: uop.op = `ALU_OR;
            CMD_AEX: uop.op = `ALU_XOR;
            CMD_ARX: uop.op = `ALU_ADD_CARRY_AROUND;
            CMD_ASX: uop.op = `ALU_SHIFT;
            CMD_ASN: begin
                uop.op    = `ALU_SHIFT;
                uop.b_sel = BSEL_SHIFT_IMM;
            end
            CMD_ACX: begin
                if (idx == 1'b0) begin
                    uop.op    = `ALU_COUNT;
                    uop.a_sel = ASEL_OPERAND;
                    uop.b_sel = BSEL_ZERO;
                    uop.last  = 1'b0;
                end else begin
                    uop.op    = `ALU_ADD_CARRY_AROUND;
                    uop.a_sel = ASEL_TEMP;
                    uop.b_sel = BSEL_ACC;
                    uop.last  = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mesm6_defines.sv
// Shared ALU micro-op encodings for the mesm6 datapath.
// Guarded so that every file needing the encodings can include it safely.
`ifndef MESM6_DEFINES_SV
`define MESM6_DEFINES_SV

`define ALU_OP_WIDTH         4
`define ALU_NOP              4'd0
`define ALU_AND              4'd1
`define ALU_OR               4'd2
`define ALU_XOR              4'd3
`define ALU_ADD_CARRY_AROUND 4'd4
`define ALU_SHIFT            4'd5
`define ALU_COUNT            4'd6

`endif

// File: rtl/mesm6_alu_seq.sv
// ALU macro-op sequencer: expands one macro into ALU micro-ops over the op/done
// handshake, owns the accumulator and Y registers, and guards against a stalled ALU.
`include "mesm6_defines.sv"

module mesm6_alu_seq
    import mesm6_alu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               cmd,
    input  logic [47:0]              operand,
    input  logic [6:0]               shift_imm,
    input  logic                     acc_we,
    input  logic [47:0]              acc_wdata,
    output logic [`ALU_OP_WIDTH-1:0] alu_op,
    output logic [47:0]              alu_a,
    output logic [47:0]              alu_b,
    input  logic [47:0]              alu_result,
    input  logic [47:0]              alu_y,
    input  logic                     alu_done,
    output logic [47:0]              acc,
    output logic [47:0]              yreg,
    output logic                     busy,
    output logic                     valid,
    output logic                     error
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t                   r_state;
    logic                     r_idx;
    logic [7:0]               r_wd;
    logic [2:0]               r_cmd;
    logic [47:0]              r_operand;
    logic [6:0]               r_shift_imm;
    logic [47:0]              r_temp;
    logic                     r_last;
    logic [`ALU_OP_WIDTH-1:0] r_op;
    logic [47:0]              r_a;
    logic [47:0]              r_b;
    logic [47:0]              r_acc;
    logic [47:0]              r_y;
    logic                     r_busy;
    logic                     r_valid;
    logic                     r_error;

    logic [2:0]  w_cmd;
    logic        w_idx;
    logic [47:0] w_acc_src;
    logic [47:0] w_operand;
    logic [6:0]  w_shift_imm;
    logic [47:0] w_a;
    logic [47:0] w_b;
    uop_t        w_uop;
    logic        w_illegal;

    // In IDLE the first uop comes from live inputs (acc_we bypasses into acc);
    // later uops come from the values latched at the accept edge.
    always_comb begin
        w_cmd       = r_cmd;
        w_idx       = r_idx + 1'b1;
        w_acc_src   = r_acc;
        w_operand   = r_operand;
        w_shift_imm = r_shift_imm;
        if (r_state == IDLE) begin
            w_cmd       = cmd;
            w_idx       = 1'b0;
            w_acc_src   = acc_we ? acc_wdata : r_acc;
            w_operand   = operand;
            w_shift_imm = shift_imm;
        end else begin
            w_cmd       = r_cmd;
            w_idx       = r_idx + 1'b1;
            w_acc_src   = r_acc;
            w_operand   = r_operand;
            w_shift_imm = r_shift_imm;
        end
    end

    mesm6_alu_uop_rom u_rom (
        .cmd     (w_cmd),
        .idx     (w_idx),
        .uop     (w_uop),
        .illegal (w_illegal)
    );

    // Operand A source select.
    always_comb begin
        w_a = 48'd0;
        case (w_uop.a_sel)
            ASEL_ACC:     w_a = w_acc_src;
            ASEL_OPERAND: w_a = w_operand;
            ASEL_TEMP:    w_a = r_temp;
            default:      w_a = 48'd0;
        endcase
    end

    // Operand B source select.
    always_comb begin
        w_b = 48'd0;
        case (w_uop.b_sel)
            BSEL_OPERAND:   w_b = w_operand;
            BSEL_SHIFT_IMM: w_b = shift_word(w_shift_imm);
            BSEL_ZERO:      w_b = 48'd0;
            BSEL_ACC:       w_b = w_acc_src;
            default:        w_b = 48'd0;
        endcase
    end

    // Sequencer FSM, handshake outputs, watchdog and acc/Y ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 1'b0;
            r_wd        <= 8'd0;
            r_cmd       <= 3'd0;
            r_operand   <= 48'd0;
            r_shift_imm <= 7'd0;
            r_temp      <= 48'd0;
            r_last      <= 1'b0;
            r_op        <= `ALU_NOP;
            r_a         <= 48'd0;
            r_b         <= 48'd0;
            r_acc       <= 48'd0;
            r_y         <= 48'd0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (acc_we) begin
                        r_acc <= acc_wdata;
                    end else begin
                        r_acc <= r_acc;
                    end
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_cmd       <= cmd;
                        r_operand   <= operand;
                        r_shift_imm <= shift_imm;
                        r_idx       <= 1'b0;
                        r_wd        <= 8'd0;
                        if (w_illegal) begin
                            // No ALU traffic: flag and drain through RELEASE.
                            r_error <= 1'b1;
                            r_last  <= 1'b1;
                            r_state <= RELEASE;
                        end else begin
                            r_op    <= w_uop.op;
                            r_a     <= w_a;
                            r_b     <= w_b;
                            r_last  <= w_uop.last;
                            r_state <= ISSUE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (alu_done) begin
                        r_op    <= `ALU_NOP;
                        r_state <= RELEASE;
                        if (r_last) begin
                            r_acc   <= alu_result;
                            r_y     <= alu_y;
                            r_valid <= 1'b1;
                        end else begin
                            r_temp <= alu_result;
                        end
                    end else if (r_wd == WD_LAST) begin
                        r_op    <= `ALU_NOP;
                        r_error <= 1'b1;
                        r_last  <= 1'b1;
                        r_state <= RELEASE;
                    end else begin
                        r_wd <= r_wd + 8'd1;
                    end
                end
                RELEASE: begin
                    if (r_last) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_op    <= w_uop.op;
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_last  <= w_uop.last;
                        r_idx   <= r_idx + 1'b1;
                        r_wd    <= 8'd0;
                        r_state <= ISSUE;
                    end
                end
                default: begin
                    r_op    <= `ALU_NOP;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_op = r_op;
    assign alu_a  = r_a;
    assign alu_b  = r_b;
    assign acc    = r_acc;
    assign yreg   = r_y;
    assign busy   = r_busy;
    assign valid  = r_valid;
    assign error  = r_error;

endmodule

// File: tb/tb_mesm6_alu_seq.sv
// Self-checking bench for mesm6_alu_seq: a behavioural ALU responder plus a
// macro-level reference model, driven by directed and randomized macro-ops.
module tb_mesm6_alu_seq;

    localparam int TIMEOUT = 16;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SHIFT = 4'd5;
    localparam logic [3:0] OP_COUNT = 4'd6;

    localparam logic [2:0] C_AAX = 3'd0;
    localparam logic [2:0] C_AOX = 3'd1;
    localparam logic [2:0] C_AEX = 3'd2;
    localparam logic [2:0] C_ARX = 3'd3;
    localparam logic [2:0] C_ASX = 3'd4;
    localparam logic [2:0] C_ASN = 3'd5;
    localparam logic [2:0] C_ACX = 3'd6;
    localparam logic [2:0] C_BAD = 3'd7;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  cmd;
    logic [47:0] operand;
    logic [6:0]  shift_imm;
    logic        acc_we;
    logic [47:0] acc_wdata;
    logic [3:0]  alu_op;
    logic [47:0] alu_a;
    logic [47:0] alu_b;
    logic [47:0] alu_result;
    logic [47:0] alu_y;
    logic        alu_done;
    logic [47:0] acc;
    logic [47:0] yreg;
    logic        busy;
    logic        valid;
    logic        error;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          alu_stall = 1'b0;
    int          alu_cnt;
    logic [47:0] m_acc;
    logic [47:0] m_y;

    mesm6_alu_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cmd        (cmd),
        .operand    (operand),
        .shift_imm  (shift_imm),
        .acc_we     (acc_we),
        .acc_wdata  (acc_wdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_y      (alu_y),
        .alu_done   (alu_done),
        .acc        (acc),
        .yreg       (yreg),
        .busy       (busy),
        .valid      (valid),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU semantics: returns {result, y}. Shift b = {dir(1=right), amount[5:0], ...}.
    function automatic logic [95:0] alu_eval(input logic [3:0] op, input logic [47:0] a, input logic [47:0] b);
        logic [48:0] s;
        logic [95:0] w;
        int          n;
        case (op)
            OP_AND: return {a & b, 48'd0};
            OP_OR:  return {a | b, 48'd0};
            OP_XOR: return {a ^ b, 48'd0};
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                return {s[47:0] + {47'd0, s[48]}, 48'd0};
            end
            OP_SHIFT: begin
                n = int'(b[46:41]);
                if (b[47]) begin
                    w = {a, 48'd0} >> n;
                    return w;
                end else begin
                    w = {48'd0, a} << n;
                    return {w[47:0], w[95:48]};
                end
            end
            OP_COUNT: return {48'($countones(a)), 48'd0};
            default:  return 96'd0;
        endcase
    endfunction

    function automatic int op_latency(input logic [3:0] op);
        return (op == OP_ADD) ? 2 : 1;
    endfunction

    // Macro-level reference: what acc/yreg must become after a command.
    function automatic logic [95:0] ref_cmd(input logic [2:0] c, input logic [47:0] a,
                                            input logic [47:0] opnd, input logic [6:0] sh);
        logic [95:0] t;
        case (c)
            C_AAX: return alu_eval(OP_AND, a, opnd);
            C_AOX: return alu_eval(OP_OR, a, opnd);
            C_AEX: return alu_eval(OP_XOR, a, opnd);
            C_ARX: return alu_eval(OP_ADD, a, opnd);
            C_ASX: return alu_eval(OP_SHIFT, a, opnd);
            C_ASN: return alu_eval(OP_SHIFT, a, {sh, 41'd0});
            C_ACX: begin
                t = alu_eval(OP_COUNT, opnd, 48'd0);
                return alu_eval(OP_ADD, t[95:48], a);
            end
            default: return {a, m_y};
        endcase
    endfunction

    // Responder ALU: done is sticky until op returns to NOP; stall suppresses done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_done   <= 1'b0;
            alu_cnt    <= 0;
            alu_result <= 48'd0;
            alu_y      <= 48'd0;
        end else if (alu_op == OP_NOP) begin
            alu_done <= 1'b0;
            alu_cnt  <= 0;
        end else if (!alu_done && !alu_stall) begin
            if (alu_cnt + 1 >= op_latency(alu_op)) begin
                alu_done               <= 1'b1;
                {alu_result, alu_y}    <= alu_eval(alu_op, alu_a, alu_b);
            end else begin
                alu_cnt <= alu_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one macro-op and check timing, handshake shape and writeback.
    task automatic run_op(input string name, input logic [2:0] c, input logic we,
                          input logic [47:0] wd, input logic [47:0] opnd, input logic [6:0] sh);
        logic [47:0] acc_in;
        logic [95:0] expv;
        int lat, nu, first_valid, nvalid, first_err, nerr, busy_low, runs, gap, gaps_bad;
        bit prev_active, nop_at_valid, busy0, stray;
        acc_in = we ? wd : m_acc;
        expv   = ref_cmd(c, acc_in, opnd, sh);
        case (c)
            C_ARX:   begin lat = 3; nu = 1; end
            C_ACX:   begin lat = 6; nu = 2; end
            default: begin lat = 2; nu = 1; end
        endcase
        stray = (c != C_BAD);
        first_valid = -1; nvalid = 0; first_err = -1; nerr = 0; busy_low = -1;
        runs = 0; gap = 0; gaps_bad = 0; prev_active = 1'b0; nop_at_valid = 1'b1;

        @(negedge clk);
        start = 1'b1; cmd = c; acc_we = we; acc_wdata = wd; operand = opnd; shift_imm = sh;
        @(posedge clk);
        #1;
        start = 1'b0; acc_we = 1'b0;
        operand = 48'({$urandom, $urandom}); shift_imm = 7'($urandom);
        busy0 = busy;
        for (int n = 0; n < 80; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (n == 1 && stray) begin
                start = 1'b1; cmd = 3'($urandom_range(0, 6));
                acc_we = 1'b1; acc_wdata = 48'({$urandom, $urandom});
            end
            if (n == 2) begin
                start = 1'b0; acc_we = 1'b0;
            end
            if (alu_op != OP_NOP) begin
                if (!prev_active) begin
                    runs++;
                    if (runs > 1 && gap != 1) gaps_bad++;
                end
                prev_active = 1'b1;
                gap = 0;
            end else begin
                gap++;
                prev_active = 1'b0;
            end
            if (valid) begin
                nvalid++;
                if (first_valid < 0) first_valid = n;
                if (alu_op != OP_NOP) nop_at_valid = 1'b0;
            end
            if (error) begin
                nerr++;
                if (first_err < 0) first_err = n;
            end
            if (busy_low < 0 && !busy) busy_low = n;
            if (busy_low >= 0 && n >= busy_low + 2) break;
        end

        check({name, "/busy_at_accept"}, 64'(busy0), 64'd1);
        if (c == C_BAD) begin
            check({name, "/error_cycle"}, 64'(first_err), 64'(0));
            check({name, "/valid_count"}, 64'(nvalid), 64'(0));
            check({name, "/busy_fall"}, 64'(busy_low), 64'(1));
            check({name, "/alu_traffic"}, 64'(runs), 64'(0));
            check({name, "/acc"}, 64'(acc), 64'(acc_in));
            check({name, "/yreg"}, 64'(yreg), 64'(m_y));
            m_acc = acc_in;
        end else if (alu_stall) begin
            check({name, "/error_cycle"}, 64'(first_err), 64'(TIMEOUT));
            check({name, "/error_count"}, 64'(nerr), 64'(1));
            check({name, "/valid_count"}, 64'(nvalid), 64'(0));
            check({name, "/busy_fall"}, 64'(busy_low), 64'(TIMEOUT + 1));
            check({name, "/issue_phases"}, 64'(runs), 64'(1));
            check({name, "/acc"}, 64'(acc), 64'(acc_in));
            check({name, "/yreg"}, 64'(yreg), 64'(m_y));
            m_acc = acc_in;
        end else begin
            check({name, "/valid_cycle"}, 64'(first_valid), 64'(lat));
            check({name, "/valid_count"}, 64'(nvalid), 64'(1));
            check({name, "/error_count"}, 64'(nerr), 64'(0));
            check({name, "/busy_fall"}, 64'(busy_low), 64'(lat + 1));
            check({name, "/issue_phases"}, 64'(runs), 64'(nu));
            check({name, "/nop_gap"}, 64'(gaps_bad), 64'(0));
            check({name, "/nop_at_valid"}, 64'(nop_at_valid), 64'(1));
            check({name, "/acc"}, 64'(acc), 64'(expv[95:48]));
            check({name, "/yreg"}, 64'(yreg), 64'(expv[47:0]));
            m_acc = expv[95:48];
            m_y   = expv[47:0];
        end
    endtask

    initial begin
        logic [47:0] v;
        rst_n = 1'b0; start = 1'b0; cmd = 3'd0; operand = 48'd0; shift_imm = 7'd0;
        acc_we = 1'b0; acc_wdata = 48'd0; m_acc = 48'd0; m_y = 48'd0;
        #12;
        check("reset/alu_op", 64'(alu_op), 64'(OP_NOP));
        check("reset/alu_a", 64'(alu_a), 64'd0);
        check("reset/alu_b", 64'(alu_b), 64'd0);
        check("reset/acc", 64'(acc), 64'd0);
        check("reset/yreg", 64'(yreg), 64'd0);
        check("reset/flags", {61'd0, busy, valid, error}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("aax", C_AAX, 1'b1, 48'h00_00FF_00FF, 48'h00_000F_0F0F, 7'd0);
        check("aax/acc_value", 64'(acc), 64'h0F000F);
        run_op("arx", C_ARX, 1'b1, 48'hFFFF_FFFF_FFFF, 48'd1, 7'd0);
        check("arx/acc_value", 64'(acc), 64'd1);
        run_op("acx", C_ACX, 1'b1, 48'd5, 48'hFF, 7'd0);
        check("acx/acc_value", 64'(acc), 64'd13);
        run_op("asn", C_ASN, 1'b1, 48'h123, 48'h5A5A, 7'b1_000100);
        check("asn/yreg_value", 64'(yreg), 64'h3000_0000_0000);
        run_op("asx_left", C_ASX, 1'b0, 48'd0, {1'b0, 6'd8, 41'd0}, 7'd0);

        v = 48'h1234_5678_9ABC;
        @(negedge clk);
        acc_we = 1'b1; acc_wdata = v;
        @(posedge clk);
        #1;
        acc_we = 1'b0;
        check("idle_acc_load", 64'(acc), 64'(v));
        m_acc = v;
        run_op("aox", C_AOX, 1'b0, 48'd0, 48'hF000_0000_000F, 7'd0);
        run_op("aex", C_AEX, 1'b0, 48'd0, 48'hFFFF_0000_FFFF, 7'd0);

        alu_stall = 1'b1;
        run_op("watchdog", C_AAX, 1'b0, 48'd0, 48'h0F0F, 7'd0);
        alu_stall = 1'b0;
        run_op("illegal", C_BAD, 1'b1, 48'h00AB_CDEF_0123, 48'd7, 7'd0);
        run_op("after_illegal", C_AOX, 1'b0, 48'd0, 48'h1, 7'd0);

        for (int i = 0; i < 30; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                   48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 7'($urandom));
        end

        @(negedge clk);
        start = 1'b1; cmd = C_ACX; acc_we = 1'b1; acc_wdata = 48'd5; operand = 48'hFF;
        @(posedge clk);
        #1;
        start = 1'b0; acc_we = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid/second_issue", 64'(alu_op), 64'(OP_ADD));
        rst_n = 1'b0;
        #1;
        check("rst_mid/alu_op", 64'(alu_op), 64'(OP_NOP));
        check("rst_mid/acc", 64'(acc), 64'd0);
        check("rst_mid/busy", 64'(busy), 64'd0);
        check("rst_mid/yreg", 64'(yreg), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 48'd0;
        m_y   = 48'd0;
        run_op("post_reset_aax", C_AAX, 1'b1, 48'h00FF_00FF, 48'h0F0F_0F0F, 7'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
